// File: rtl/timer_tick_pkg.sv
`default_nettype none
// ============================================================================
// timer_tick_pkg - scheduler state encoding and interval-timer s1 register map
// Rev 1.0
// ============================================================================
package timer_tick_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CFG    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CLR    = 3'd3,
      ST_VERIFY = 3'd4,
      ST_CHECK  = 3'd5,
      ST_TICK   = 3'd6,
      ST_STOP   = 3'd7
   } state_t;

   localparam logic [2:0]  STATUS         = 3'd0;
   localparam logic [2:0]  CONTROL        = 3'd1;
   localparam logic [15:0] CTRL_START     = 16'h0007;   // ITO | CONT | START
   localparam logic [15:0] CTRL_STOP      = 16'h0008;
   localparam int          STATUS_TO_BIT  = 0;
   localparam int          STATUS_RUN_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/timer_tick_channel.sv
`default_nettype none
// ============================================================================
// timer_tick_channel - software down-counter emitting a strobe every P ticks
// Rev 1.0
// ============================================================================
module timer_tick_channel
   import timer_tick_pkg::*;
#(
   parameter int TICK_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick_i,
   input  logic              enable_i,
   input  logic [TICK_W-1:0] period_i,
   output logic              expire_o
);

   logic [TICK_W-1:0] cnt_q, cnt_d;
   logic              expire_q, expire_d;

   // A disabled or zero-period channel keeps its counter primed with the period,
   // so re-enabling it waits a full period before the first strobe.
   always_comb begin
      cnt_d    = cnt_q;
      expire_d = 1'b0;
      if (!enable_i || (period_i == '0)) begin
         cnt_d = period_i;
      end else if (tick_i) begin
         if (cnt_q <= TICK_W'(1)) begin
            expire_d = 1'b1;
            cnt_d    = period_i;
         end else begin
            cnt_d = cnt_q - TICK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_d;
      end
   end

   assign expire_o = expire_q;

endmodule
`default_nettype wire

// File: rtl/timer_tick_scheduler.sv
`default_nettype none
// ============================================================================
// timer_tick_scheduler - interval-timer master: services timeouts, counts ticks
// and fans them out to per-channel expiry counters.  Rev 1.0
// ============================================================================
module timer_tick_scheduler
   import timer_tick_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int TICK_W    = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   output logic [2:0]               tmr_address,
   output logic                     tmr_chipselect,
   output logic                     tmr_write_n,
   output logic [15:0]              tmr_writedata,
   input  logic [15:0]              tmr_readdata,
   input  logic                     tmr_irq,
   input  logic [NUM_CH*TICK_W-1:0] ch_period,
   input  logic [NUM_CH-1:0]        ch_enable,
   output logic [NUM_CH-1:0]        ch_expire,
   output logic [31:0]              tick_count,
   output logic                     running,
   output logic                     fault
);

   localparam int RETRY_W = $clog2(MAX_RETRY + 1);

   state_t             state_q, state_d;
   logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
   logic               fault_q, fault_d;
   logic               running_q;
   logic [31:0]        tick_count_q;
   logic [2:0]         addr_q, addr_d;
   logic               cs_q, cs_d;
   logic               wr_n_q, wr_n_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               tick;
   logic               unused_rd_bits;

   assign tick           = (state_q == ST_TICK);
   assign retry_inc      = retry_q + RETRY_W'(1);
   assign unused_rd_bits = ^tmr_readdata[15:2];

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (!enable)       fault_d = 1'b0;
            else if (!fault_q) state_d = ST_CFG;
         end
         ST_CFG:    state_d = ST_WAIT;
         ST_WAIT: begin
            if (!enable)      state_d = ST_STOP;
            else if (tmr_irq) state_d = ST_CLR;
         end
         ST_CLR:    state_d = ST_VERIFY;
         ST_VERIFY: state_d = ST_CHECK;
         ST_CHECK: begin
            // readdata holds the status word requested during VERIFY
            if (tmr_readdata[STATUS_TO_BIT]) begin
               if (retry_inc == RETRY_W'(MAX_RETRY)) begin
                  fault_d = 1'b1;
                  retry_d = '0;
                  state_d = ST_STOP;
               end else begin
                  retry_d = retry_inc;
                  state_d = ST_CLR;
               end
            end else begin
               retry_d = '0;
               state_d = tmr_readdata[STATUS_RUN_BIT] ? ST_TICK : ST_CFG;
            end
         end
         ST_TICK:   state_d = ST_WAIT;
         ST_STOP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Bus cycle for the state being entered, so the access is registered.
   always_comb begin
      cs_d    = 1'b0;
      wr_n_d  = 1'b1;
      addr_d  = STATUS;
      wdata_d = 16'h0000;
      case (state_d)
         ST_CFG: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = CONTROL; wdata_d = CTRL_START;
         end
         ST_CLR: begin
            cs_d = 1'b1; wr_n_d = 1'b0;
         end
         ST_VERIFY: cs_d = 1'b1;
         ST_STOP: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = CONTROL; wdata_d = CTRL_STOP;
         end
         default: cs_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         retry_q      <= '0;
         fault_q      <= 1'b0;
         running_q    <= 1'b0;
         tick_count_q <= 32'd0;
         addr_q       <= 3'd0;
         cs_q         <= 1'b0;
         wr_n_q       <= 1'b1;
         wdata_q      <= 16'h0000;
      end else begin
         state_q   <= state_d;
         retry_q   <= retry_d;
         fault_q   <= fault_d;
         running_q <= (state_d != ST_IDLE);
         addr_q    <= addr_d;
         cs_q      <= cs_d;
         wr_n_q    <= wr_n_d;
         wdata_q   <= wdata_d;
         if (tick) tick_count_q <= tick_count_q + 32'd1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_tick_channel #(.TICK_W(TICK_W)) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .tick_i   (tick),
         .enable_i (ch_enable[g]),
         .period_i (ch_period[g*TICK_W +: TICK_W]),
         .expire_o (ch_expire[g])
      );
   end

   assign tmr_address    = addr_q;
   assign tmr_chipselect = cs_q;
   assign tmr_write_n    = wr_n_q;
   assign tmr_writedata  = wdata_q;
   assign tick_count     = tick_count_q;
   assign running        = running_q;
   assign fault          = fault_q;

endmodule
`default_nettype wire
